uart_rx: RTL and testbench

- 8N1 UART receiver clocked directly by a baud-rate clock, one clock period per bit (1x sampling).
- Converts the serial line `rx_data_in` into parallel bytes.
- Presents each byte on `rx_data` with a one-cycle `rx_valid` strobe.
- Sits between the pad-level RX line and byte-consuming logic (FIFO/command parser); baud generation is external.

---
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 1x sampling on baud_clk.
// Ports: baud_clk, reset (async, high), rx_data_in -> rx_data, rx_valid, rx_frame_err.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 rx_data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d;
  logic                 err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 s;

  // Synchronizer resets to all ones so the line reads idle.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_data_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = rx_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // LSB arrives first, so shift in from the top.
        shreg_d = {s, shreg_q[DATA_BITS-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (s) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line must not read as repeated start bits.
        if (s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Driver pushes expected strobes with due cycle; monitor checks every cycle.
module tb_uart_rx;

  logic       baud_clk;
  logic       reset;
  logic       rx_data_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .baud_clk    (baud_clk),
    .reset       (reset),
    .rx_data_in  (rx_data_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_data = 8'h00;

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Monitor: strobes and held data compared once per cycle.
  always @(posedge baud_clk) begin
    bit ev;
    bit ee;
    #1;
    ev = 1'b0;
    ee = 1'b0;
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      failures++;
      $display("FAIL stale_expect due=%0d now=%0d", q[0].due, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].is_err) begin
        ee = 1'b1;
      end else begin
        ev = 1'b1;
        model_data = q[0].d;
      end
      void'(q.pop_front());
    end
    checks++;
    if (rx_valid !== ev) begin
      failures++;
      $display("FAIL rx_valid cyc=%0d got=%b exp=%b", cyc, rx_valid, ev);
    end
    checks++;
    if (rx_frame_err !== ee) begin
      failures++;
      $display("FAIL rx_frame_err cyc=%0d got=%b exp=%b", cyc, rx_frame_err, ee);
    end
    checks++;
    if (rx_data !== model_data) begin
      failures++;
      $display("FAIL rx_data cyc=%0d got=%h exp=%h", cyc, rx_data, model_data);
    end
  end

  // Frame on the pin: start, 8 data LSB first, stop, optional
  // extra low bits (bad stop only), then idle-high bits.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                            input int low_extra, input int idle_after);
    exp_t e;
    @(negedge baud_clk);
    rx_data_in = 1'b0;
    e.is_err = !stop_ok;
    e.d      = d;
    e.due    = cyc + 12;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      @(negedge baud_clk);
      rx_data_in = d[i];
    end
    @(negedge baud_clk);
    rx_data_in = stop_ok;
    repeat (low_extra) @(negedge baud_clk);
    repeat (idle_after) begin
      @(negedge baud_clk);
      rx_data_in = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge baud_clk);
      rx_data_in = 1'b1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    rx_data_in = 1'b1;
    repeat (2) @(negedge baud_clk);
    reset = 1'b0;
    idle(6);

    send_frame(8'hA5, 1'b1, 0, 3);

    send_frame(8'hC3, 1'b1, 0, 2);
    send_frame(8'hD5, 1'b1, 0, 3);

    send_frame(8'h3C, 1'b1, 0, 0);
    send_frame(8'h81, 1'b1, 0, 3);

    send_frame(8'h55, 1'b0, 5, 2);
    send_frame(8'h5A, 1'b1, 0, 3);

    // Abort a 0xFF frame during data bit 4 with reset.
    idle(4);
    @(negedge baud_clk);
    rx_data_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge baud_clk);
      rx_data_in = 1'b1;
    end
    @(posedge baud_clk);
    #2;
    reset      = 1'b1;
    rx_data_in = 1'b1;
    model_data = 8'h00;
    repeat (2) @(negedge baud_clk);
    reset = 1'b0;
    idle(3);
    send_frame(8'h12, 1'b1, 0, 3);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit         ok;
      int         lx;
      int         gap;
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 9) != 0);
      lx  = ok ? 0 : int'($urandom_range(0, 4));
      gap = ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      send_frame(d, ok, lx, gap);
    end

    idle(16);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expect got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
